// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: oversampled, majority-voted UART RX frame controller.
// Define UART_RX_PARITY_EN to compile in the parity bit and par_err.
module uart_rx_frame_ctrl #(
    parameter int OVERSAMPLE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    input  logic par_en,
    input  logic par_typ,
    output logic sampled_bit,
    output logic deser_en,
    output logic data_valid,
    output logic par_err,
    output logic stp_err
);

    localparam int EW = $clog2(OVERSAMPLE);
    localparam int H  = OVERSAMPLE / 2;

    localparam logic [EW-1:0] E_LAST = EW'(OVERSAMPLE - 1);
    localparam logic [EW-1:0] E_S0   = EW'(H - 1);
    localparam logic [EW-1:0] E_S1   = EW'(H);
    localparam logic [EW-1:0] E_S2   = EW'(H + 1);
    localparam logic [EW-1:0] E_MID  = EW'(H + 2);

    if (OVERSAMPLE != 8 && OVERSAMPLE != 16 &&
        OVERSAMPLE != 32) begin : g_bad_os
        $error("OVERSAMPLE must be 8, 16 or 32");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [EW-1:0]   edge_cnt;
    logic [EW-1:0]   edge_cnt_nx;
    logic [3:0]      bit_cnt;
    logic [3:0]      bit_cnt_nx;
    logic            smp0;
    logic            smp1;
    logic            edge_last;
    logic            edge_mid;
    logic            start_det;
    logic            dv_nx;
    logic            se_nx;
    logic            par_on;
    logic            par_flag;

    assign edge_last = (edge_cnt == E_LAST);
    assign edge_mid  = (edge_cnt == E_MID);

    // Three samples around mid-bit; the vote lands at edge H+2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp0        <= 1'b0;
            smp1        <= 1'b0;
            sampled_bit <= 1'b0;
        end else if (state != IDLE) begin
            if (edge_cnt == E_S0)
                smp0 <= rx_in;
            if (edge_cnt == E_S1)
                smp1 <= rx_in;
            if (edge_cnt == E_S2)
                sampled_bit <= (smp0 & smp1) |
                               (smp0 & rx_in) |
                               (smp1 & rx_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            data_valid <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            edge_cnt   <= edge_cnt_nx;
            bit_cnt    <= bit_cnt_nx;
            data_valid <= dv_nx;
            stp_err    <= se_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        edge_cnt_nx = edge_cnt + 1'b1;
        bit_cnt_nx  = bit_cnt;
        deser_en    = 1'b0;
        dv_nx       = 1'b0;
        se_nx       = 1'b0;
        start_det   = 1'b0;
        if (edge_last)
            bit_cnt_nx = bit_cnt + 1'b1;
        unique case (state)
            IDLE: begin
                edge_cnt_nx = '0;
                bit_cnt_nx  = '0;
                if (!rx_in) begin
                    state_nx    = START;
                    edge_cnt_nx = EW'(1);
                    start_det   = 1'b1;
                end
            end
            START: begin
                if (edge_last) begin
                    if (sampled_bit) begin
                        state_nx   = IDLE;
                        bit_cnt_nx = '0;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                deser_en = edge_mid;
                if (edge_last && bit_cnt == 4'd8)
                    state_nx = par_on ? PARITY : STOP;
            end
            PARITY: begin
                if (edge_last)
                    state_nx = STOP;
            end
            STOP: begin
                if (edge_last) begin
                    state_nx   = IDLE;
                    bit_cnt_nx = '0;
                    se_nx      = ~sampled_bit;
                    dv_nx      = sampled_bit & ~par_flag;
                end
            end
            default: begin
                state_nx    = IDLE;
                edge_cnt_nx = '0;
                bit_cnt_nx  = '0;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic par_en_q;
    logic par_typ_q;
    logic par_acc;
    logic par_bad;

    assign par_on  = par_en_q;
    assign par_bad = sampled_bit ^ par_acc ^ par_typ_q;

    // Frame config is frozen at start detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_acc   <= 1'b0;
            par_flag  <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            par_err <= 1'b0;
            if (start_det) begin
                par_en_q  <= par_en;
                par_typ_q <= par_typ;
                par_acc   <= 1'b0;
                par_flag  <= 1'b0;
            end
            if (deser_en)
                par_acc <= par_acc ^ sampled_bit;
            if (state == PARITY && edge_mid && par_bad) begin
                par_flag <= 1'b1;
                par_err  <= 1'b1;
            end
        end
    end
`else
    logic unused_cfg;

    assign par_on     = 1'b0;
    assign par_flag   = 1'b0;
    assign par_err    = 1'b0;
    assign unused_cfg = ^{par_en, par_typ, start_det};
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: scoreboard bench for uart_rx_frame_ctrl.
// Expected strobes/events are queued at frame launch, popped on output.
module tb_uart_rx_frame_ctrl;

    localparam int OS = 8;
    localparam logic [2:0] K_DV = 3'b001;
    localparam logic [2:0] K_PE = 3'b010;
    localparam logic [2:0] K_SE = 3'b100;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_in;
    logic par_en;
    logic par_typ;
    logic sampled_bit;
    logic deser_en;
    logic data_valid;
    logic par_err;
    logic stp_err;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        logic [2:0] kind;
        int         at;
        logic [7:0] data;
    } ev_t;

    ev_t        ev_q[$];
    int         de_q[$];
    logic [7:0] shreg = 8'h00;
    logic [2:0] kind_obs;
    ev_t        ev;

    uart_rx_frame_ctrl #(.OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .sampled_bit(sampled_bit),
        .deser_en   (deser_en),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Monitor: downstream shift register plus scoreboard pops.
    always @(negedge clk) begin
        if (rst_n) begin
            kind_obs = {stp_err, par_err, data_valid};
            if (deser_en) begin
                shreg = {sampled_bit, shreg[7:1]};
                if (de_q.size() == 0)
                    check("deser_unexpected", de_q.size(), 1);
                else
                    check("deser_cycle", cyc, de_q.pop_front());
            end
            if (kind_obs != 3'b000) begin
                if (ev_q.size() == 0) begin
                    check("event_unexpected", kind_obs, 0);
                end else begin
                    ev = ev_q.pop_front();
                    check("event_kind", kind_obs, ev.kind);
                    check("event_cycle", cyc, ev.at);
                    if (ev.kind == K_DV)
                        check("event_byte", shreg, ev.data);
                end
            end
        end
    end

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_sampled"}, sampled_bit, 0);
        check({tag, "_deser_en"}, deser_en, 0);
        check({tag, "_data_valid"}, data_valid, 0);
        check({tag, "_par_err"}, par_err, 0);
        check({tag, "_stp_err"}, stp_err, 0);
    endtask

    // perr flips the sent parity bit; nk/ne place a 1-cycle glitch.
    task automatic send(input logic [7:0] b,
                        input logic pe,
                        input logic pt,
                        input logic perr,
                        input logic stop,
                        input int nk,
                        input int ne);
        int t;
        int nb;
        logic use_par;
        logic pbit;
        logic v;
        t = cyc;
        use_par = 1'b0;
`ifdef UART_RX_PARITY_EN
        use_par = pe;
`endif
        pbit = (^b) ^ pt ^ perr;
        par_en = pe;
        par_typ = pt;
        for (int j = 0; j < 8; j++)
            de_q.push_back(t + 14 + 8 * j);
        if (use_par) begin
            nb = 11;
            if (perr)
                ev_q.push_back('{K_PE, t + 79, 8'h00});
            if (!stop)
                ev_q.push_back('{K_SE, t + 88, 8'h00});
            else if (!perr)
                ev_q.push_back('{K_DV, t + 88, b});
        end else begin
            nb = 10;
            if (!stop)
                ev_q.push_back('{K_SE, t + 80, 8'h00});
            else
                ev_q.push_back('{K_DV, t + 80, b});
        end
        for (int k = 0; k < nb; k++) begin
            if (k == 0)
                v = 1'b0;
            else if (k <= 8)
                v = b[k-1];
            else if (k == nb - 1)
                v = stop;
            else
                v = pbit;
            for (int e = 0; e < OS; e++) begin
                rx_in = v ^ ((k == nk) && (e == ne));
                if (k == 5 && e == 0) begin
                    par_en = ~pe;
                    par_typ = ~pt;
                end
                @(posedge clk);
                #1;
            end
        end
        rx_in = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        rx_in = 1'b1;
        par_en = 1'b0;
        par_typ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("in_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_quiet("post_reset");
        idle(200);

        send(8'hA5, 0, 0, 0, 1, -1, -1);
        idle(10);
        send(8'h3C, 1, 0, 0, 1, -1, -1);
        idle(10);
        send(8'h3C, 1, 0, 1, 1, -1, -1);
        idle(10);
        send(8'h3C, 1, 1, 0, 1, -1, -1);
        idle(10);
        send(8'h55, 0, 0, 0, 0, -1, -1);
        idle(10);
        send(8'h55, 1, 1, 0, 0, -1, -1);
        idle(10);

        t = cyc;
        for (int i = 0; i < 20; i++) begin
            rx_in = (i < 2) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
        end
        check("glitch_launch", cyc, t + 20);
        send(8'h96, 0, 0, 0, 1, -1, -1);
        idle(10);

        send(8'h01, 0, 0, 0, 1, -1, -1);
        send(8'hFE, 0, 0, 0, 1, -1, -1);
        idle(10);
        send(8'h5A, 0, 0, 0, 1, 4, 4);
        idle(10);

        t = cyc;
        for (int j = 0; j < 4; j++)
            de_q.push_back(t + 14 + 8 * j);
        for (int i = 0; i < 40; i++) begin
            rx_in = (i < 8) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check_quiet("abort");
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(100);
        send(8'hC3, 0, 0, 0, 1, -1, -1);
        idle(20);

        check("event_queue_empty", ev_q.size(), 0);
        check("deser_queue_empty", de_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Receive-side frame controller for the UART RX path. Oversamples the synchronized serial line, majority-votes each bit, walks the start/data/parity/stop sequence, and drives the serial-to-parallel stage. It supplies `sampled_bit` and a one-cycle `deser_en` per data bit, LSB first, to the 8-bit shift-register deserializer directly downstream. It reports frame completion and errors to the RX top level.

## Interface

**Parameters**
- `OVERSAMPLE`, default 8: clock cycles per bit. Legal values are 8, 16 and 32.

**Ports** (name, direction, width, meaning)
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `rx_in`, input, 1: serial line, already synchronized to `clk`. Idle level is high.
- `par_en`, input, 1: parity bit present in the frame.
- `par_typ`, input, 1: parity type, 0 = even, 1 = odd.
- `sampled_bit`, output, 1: majority-voted value of the current bit, feeds the deserializer.
- `deser_en`, output, 1: one-cycle shift strobe to the deserializer.
- `data_valid`, output, 1: one-cycle pulse; the deserializer holds a good byte.
- `par_err`, output, 1: one-cycle pulse on parity mismatch.
- `stp_err`, output, 1: one-cycle pulse on a low stop bit.

## Operation

**Counters**
- `edge_cnt` is log2(OVERSAMPLE) bits wide.
- In every state except IDLE it increments each cycle and wraps from OVERSAMPLE-1 to 0.
- `bit_cnt` is 4 bits wide and increments on each `edge_cnt` wrap.
- Let H = OVERSAMPLE/2.

**Sampling**
- Samples are taken at `edge_cnt` = H-1, H and H+1.
- `sampled_bit` is registered with the 2-of-3 majority.
- It is valid from edge H+2 and holds until the next bit's H+2.

**State machine**
- IDLE: `edge_cnt` and `bit_cnt` are 0. When `rx_in`=0, that cycle is edge 0 of the start bit: go to START, load `edge_cnt`=1, and latch `par_en` and `par_typ`.
- START: at edge OVERSAMPLE-1, go to DATA if `sampled_bit`=0. Otherwise the start was a glitch: go to IDLE with no outputs.
- DATA:
  - `deser_en`=1 exactly in the cycle where `edge_cnt`=H+2.
  - The running XOR of the data bits is updated in that same cycle.
  - After the 8th bit ends, go to PARITY if parity is enabled (see Configuration), else to STOP.
- PARITY: at edge H+2, compare `sampled_bit` against XOR ^ `par_typ`. A mismatch sets an internal error flag and pulses `par_err` in the next cycle. At the end of the bit, go to STOP.
- STOP:
  - At edge OVERSAMPLE-1, go to IDLE.
  - If `sampled_bit`=0, pulse `stp_err` in the next cycle.
  - If the stop bit is good and there was no parity error, pulse `data_valid` in the next cycle instead.
- `rx_in` low in the first IDLE cycle after STOP starts the next frame, so back-to-back frames are supported.
- Changes on `par_en` or `par_typ` during a frame are ignored; the values latched at start detection apply.

## Timing

- Reset value of every output and counter is 0; the state resets to IDLE.
- Asserting `rst_n` low mid-frame aborts immediately. No `data_valid` or error pulse is issued for the aborted frame.
- Let T be the cycle in which `rx_in`=0 is first seen in IDLE. Bit k occupies cycles T+k·OVERSAMPLE through T+k·OVERSAMPLE+OVERSAMPLE-1, where k=0 is start, k=1..8 are data, then parity if enabled, then stop.
- `data_valid` timing:
  - No parity: cycle T+10·OVERSAMPLE.
  - With parity: cycle T+11·OVERSAMPLE.
- `data_valid`, `par_err` and `stp_err` are each exactly one cycle wide.
- `data_valid` never coincides with either error pulse.
- `par_err` pulses at the cycle after edge H+2 of the parity bit.
- `stp_err` pulses at the same cycle `data_valid` would have.
- `deser_en` pulses exactly 8 times per accepted frame and never during START, PARITY or STOP.

## Configuration

- `UART_RX_PARITY_EN` defined: PARITY state, parity XOR and `par_err` are compiled in, and operation follows `par_en`/`par_typ`.
- Not defined: `par_en` and `par_typ` are ignored, DATA goes straight to STOP, and `par_err` is tied to 0. Frames are always 10 bits.

## Test plan

All scenarios use OVERSAMPLE=8.
- Reset: hold `rst_n`=0, then release with `rx_in`=1 → all outputs 0, no pulses for 200 cycles.
- Byte 0xA5, no parity, start at cycle T → `deser_en` at T+14+8j for j=0..7; `data_valid` at T+80; the deserializer reads 0xA5.
- Byte 0x3C, `par_en`=1, `par_typ`=0, parity bit 0 → `data_valid` at T+88 and no `par_err`. Repeat with parity bit 1 → `par_err` at T+79 and no `data_valid`.
- Byte 0x55, stop bit driven 0 → `stp_err` at T+80 and no `data_valid`.
- Glitch: `rx_in` low for 2 cycles then high → return to IDLE at T+8, zero `deser_en` pulses; a valid frame starting at T+20 is received correctly.
- Two back-to-back frames, 0x01 then 0xFE, plus a frame with 1-cycle noise inverting edge 4 of data bit 3 → `data_valid` twice with correct bytes; the majority vote corrects the noise.
